// File: rtl/pipe_pkg.sv
// Shared types and constants for back-pressurable pipeline stages.
package pipe_pkg;

  localparam int PIPE_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc high, holds at all-ones.
// One-cycle update latency; cleared only by synchronous reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline register with valid/ready handshake, flush and stall counter.
// One-cycle latency; in_ready comes only from registered state, flush and reset.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_state_t     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;

  // Reset gating keeps upstream from seeing a ready stage while held in reset.
  assign in_ready  = (state_q != FULL) & ~flush & ~reset;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only drops the full flags; payload registers keep their contents.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with a queue-based reference model checked every cycle.
module tb_pipe_stage_skid;

  localparam int W     = 32;
  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of held entries plus the last value shown at the head.
  logic [W-1:0] mq[$];
  logic [W-1:0] shown = '0;
  int           mcnt  = 0;
  bit           started = 0;

  always @(posedge clk) begin
    bit ov, ir, of_m, if_m;
    if (reset) begin
      mq.delete();
      shown   = '0;
      mcnt    = 0;
      started = 1;
    end else if (started) begin
      ov   = (mq.size() != 0);
      ir   = (mq.size() < 2) && !flush;
      of_m = ov && out_ready;
      if_m = in_valid && ir;
      if (ov && !out_ready && mcnt < CMAX) mcnt++;
      if (of_m) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (if_m) mq.push_back(in_data);
      if (mq.size() != 0) shown = mq[0];
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready",  32'(in_ready),  32'(!reset && (mq.size() < 2) && !flush));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_data",  out_data,       shown);
      chk("stall_cnt", 32'(stall_cnt), 32'(mcnt));
    end
  end

  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [W-1:0] d, input logic ordy);
    reset     = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  out_data,       0);
    chk("rst_stall",     32'(stall_cnt), 0);

    // streaming at full rate
    cyc(0, 0, 1, 32'h11, 1);
    chk("lit_stream0", out_data, 32'h11);
    cyc(0, 0, 1, 32'h22, 1);
    chk("lit_stream1", out_data, 32'h22);
    cyc(0, 0, 1, 32'h33, 1);
    chk("lit_stream2", out_data, 32'h33);
    cyc(0, 0, 0, 0, 1);
    chk("lit_stream_done", 32'(out_valid), 0);
    chk("lit_stream_stall", 32'(stall_cnt), 0);

    // back-pressure fill: A, B held; C waits upstream
    cyc(0, 0, 1, 32'hA, 0);
    cyc(0, 0, 1, 32'hB, 0);
    cyc(0, 0, 1, 32'hC, 0);
    chk("lit_bp_head",  out_data, 32'hA);
    chk("lit_bp_ready", 32'(in_ready), 0);
    cyc(0, 0, 1, 32'hC, 0);
    cyc(0, 0, 1, 32'hC, 1);
    chk("lit_bp_second", out_data, 32'hB);
    cyc(0, 0, 1, 32'hC, 1);
    chk("lit_bp_third", out_data, 32'hC);
    cyc(0, 0, 0, 0, 1);
    chk("lit_bp_stall", 32'(stall_cnt), 3);

    // flush while FULL, concurrent offer not accepted
    cyc(0, 0, 1, 32'h5, 0);
    cyc(0, 0, 1, 32'h6, 0);
    cyc(0, 1, 1, 32'h7, 0);
    chk("lit_fl_valid", 32'(out_valid), 0);
    chk("lit_fl_stall", 32'(stall_cnt), 5);
    chk("lit_fl_data",  out_data, 32'h5);
    cyc(0, 0, 1, 32'h7, 0);
    chk("lit_fl_accept", out_data, 32'h7);
    cyc(0, 0, 0, 0, 1);

    // flush coinciding with out_fire
    cyc(0, 0, 1, 32'h9, 0);
    cyc(0, 1, 0, 0, 1);
    chk("lit_flo_empty", 32'(out_valid), 0);
    cyc(0, 0, 0, 0, 1);
    chk("lit_flo_still_empty", 32'(out_valid), 0);

    // counter saturation
    cyc(0, 0, 1, 32'h44, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
    chk("lit_sat", 32'(stall_cnt), CMAX);
    cyc(0, 0, 0, 0, 0);
    chk("lit_sat_hold", 32'(stall_cnt), CMAX);
    cyc(0, 0, 0, 0, 1);

    // reset with two entries held
    cyc(0, 0, 1, 32'h55, 0);
    cyc(0, 0, 1, 32'h66, 0);
    cyc(1, 0, 1, 32'h77, 0);
    chk("lit_rst_valid", 32'(out_valid), 0);
    chk("lit_rst_data",  out_data, 0);
    chk("lit_rst_stall", 32'(stall_cnt), 0);
    cyc(0, 0, 0, 0, 1);
    chk("lit_rst_ready", 32'(in_ready), 1);

    // mixed traffic for the per-cycle model check
    for (int i = 0; i < 40; i++)
      cyc(0, (i % 13) == 7, (i % 3) != 0, 32'h100 + i, (i % 4) < 2);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, back-pressurable pipeline stage register that generalises the fixed MEM/WB register into a reusable stage between any two pipeline stages of the RISC-V core. It carries an arbitrary-width payload under a valid/ready handshake and uses a two-entry skid buffer, so that `in_ready` depends only on stage state and `flush`. It supports synchronous flush and keeps a saturating back-pressure stall counter for performance monitoring.

## Interface
Parameters:
- `WIDTH`, 32: payload width in bits (≥1).
- `CNT_W`, 16: stall counter width in bits (≥1).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous discard of all held entries.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid entry.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  WIDTH  head payload; registered, no combinational path from `in_data`.
- `stall_cnt`  out  CNT_W  saturating count of back-pressure cycles.

## Operation
- Storage: `main` register (drives `out_data`) and `skid` register, each with a full flag.
- States (`pipe_pkg::stage_state_t`): EMPTY (neither full), BUSY (main full), FULL (main and skid full).
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- `in_ready = (state != FULL) & ~flush`.
- `out_valid = (state != EMPTY)`.
- EMPTY: `in_fire` → main←in_data, BUSY; otherwise stay.
- BUSY: `in_fire & out_fire` → main←in_data, stay BUSY. `in_fire & ~out_fire` → skid←in_data, FULL. `~in_fire & out_fire` → EMPTY.
- FULL: `out_fire` → main←skid, BUSY. `in_ready = 0`, so no input is accepted.
- Order is strictly FIFO; no entry is dropped or duplicated except by flush or reset.
- Flush: next state EMPTY; both full flags cleared. Data registers are not cleared. `in_ready` is 0 during flush, so concurrent input is not accepted. A concurrent `out_fire` completes normally: downstream consumes the head in that cycle.
- `stall_cnt`: increments each cycle with `out_valid & ~out_ready`, including during flush. Saturates at 2^CNT_W−1 (no wrap). Cleared only by reset.
- Priority: reset > flush > handshake.

## Timing
- Reset values: state EMPTY, `out_valid` 0, `in_ready` 0 during reset and 1 the cycle after (unless `flush`), `out_data` 0, skid 0, `stall_cnt` 0.
- Latency: accepted in cycle N (state EMPTY) → `out_valid` and `out_data` visible in cycle N+1.
- Throughput: one transfer per cycle sustained while `out_ready` is 1.
- Capacity: 2 entries. `in_ready` falls the cycle after the second unmatched acceptance.
- `in_ready` depends only on registered state and `flush`, never on `out_ready`.
- Reset asserted mid-operation: all held entries are lost in the same edge, with no partial update.

## Structure
- Package `pipe_pkg`: `stage_state_t` enum (EMPTY, BUSY, FULL) and a shared `PIPE_WIDTH_DEFAULT` = 32 constant.
- Sub-module `sat_counter` (parameter `CNT_W`; inputs `clk`, `reset`, `inc`; output `count`). It implements `stall_cnt` and is reusable for other performance counters.
- Top-level `pipe_stage_skid` holds the state machine, `main`/`skid` registers, and handshake logic.

## Test plan
- Reset then stream: `out_ready`=1; inputs 0x11, 0x22, 0x33 on consecutive cycles → `out_data` 0x11, 0x22, 0x33 one cycle later each; `in_ready` stays 1; `stall_cnt` = 0.
- Back-pressure fill: `out_ready`=0; offer 0xA, 0xB, 0xC → 0xA, 0xB accepted; `in_ready`=0 from the cycle after 0xB; 0xC is held upstream. Raise `out_ready` → output sequence 0xA, 0xB, 0xC; `stall_cnt` equals the number of `out_ready`=0 cycles with `out_valid`=1.
- Flush while FULL: hold 0x5, 0x6; pulse `flush` with `in_valid`=1 and data 0x7 → next cycle `out_valid`=0, 0x7 not accepted; the following cycle 0x7 is accepted.
- Flush with `out_fire`: BUSY with 0x9, `out_ready`=1, `flush`=1 → 0x9 consumed once; next cycle EMPTY.
- Counter saturation: `CNT_W`=3; hold `out_valid` with `out_ready`=0 for 10 cycles → `stall_cnt` = 7 and stays at 7.
- Reset mid-FULL: assert `reset` with two entries held → next cycle `out_valid`=0, `out_data`=0, `stall_cnt`=0.
